// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED matrix scanner.
package led_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    function automatic int pwm_steps(input int bpp);
        return (1 << bpp) - 1;
    endfunction

endpackage

// File: rtl/led_scan_tick.sv
// Scan tick generator: FREQDIV-bit divider that only advances while enabled.
module led_scan_tick #(
    parameter int FREQDIV = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    generate
        if (FREQDIV == 0) begin : g_nodiv
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_tick   = i_en;
        end else begin : g_div
            logic [FREQDIV-1:0] r_div;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst)
                    r_div <= '0;
                else if (i_en)
                    r_div <= r_div + 1'b1;
            end
            // Tick on the enabled cycle where the divider wraps.
            assign o_tick = i_en & (&r_div);
        end
    endgenerate

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning bicolour LED matrix driver with PWM intensity and double-buffered frames.
// Define LED_SCAN_BLANK_EN to insert dark BLANK ticks at the end of each row.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int BPP          = 2,
    parameter int FREQDIV      = 0,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                                CLK,
    input  logic                                Reset,
    input  logic                                EnableCount,
    input  logic [ROWS-1:0][COLS-1:0][BPP-1:0]  RedPixels,
    input  logic [ROWS-1:0][COLS-1:0][BPP-1:0]  GrnPixels,
    input  logic                                FrameLoad,
    output logic                                FrameAck,
    output logic [$clog2(ROWS)-1:0]             RowSel,
    output logic [COLS-1:0]                     RedCols,
    output logic [COLS-1:0]                     GrnCols,
    output logic                                FrameStart
);

    localparam int PWM_STEPS = pwm_steps(BPP);
    localparam int RW        = $clog2(ROWS);
    localparam int BW        = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [BPP-1:0] PWM_LAST  = BPP'(PWM_STEPS - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
    localparam logic [BW-1:0]  BCNT_LAST = BW'(BLANK_CYCLES - 1);

    scan_state_t r_state, w_state_nxt;
    logic [RW-1:0]  r_row, w_row_nxt;
    logic [BPP-1:0] r_pwm, w_pwm_nxt;
    logic [BW-1:0]  r_bcnt, w_bcnt_nxt;
    logic           w_tick, w_adv, w_bound, w_copy, w_start_nxt;
    logic           r_ack, r_start;
    logic [COLS-1:0] r_red_cols, r_grn_cols, w_red_cols, w_grn_cols;
    logic [ROWS-1:0][COLS-1:0][BPP-1:0] r_red_buf, r_grn_buf, w_red_disp, w_grn_disp;

    led_scan_tick #(.FREQDIV(FREQDIV)) u_tick (
        .i_clk  (CLK),
        .i_rst  (Reset),
        .i_en   (EnableCount),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_pwm_nxt   = r_pwm;
        w_bcnt_nxt  = r_bcnt;
        w_start_nxt = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_nxt = SCAN;
                    w_row_nxt   = '0;
                    w_pwm_nxt   = '0;
                    w_start_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (w_tick) begin
                    if (r_pwm == PWM_LAST) begin
`ifdef LED_SCAN_BLANK_EN
                        w_state_nxt = BLANK;
                        w_bcnt_nxt  = '0;
`else
                        w_adv = 1'b1;
`endif
                    end else begin
                        w_pwm_nxt = r_pwm + 1'b1;
                    end
                end
            end
            BLANK: begin
                if (w_tick) begin
                    if (r_bcnt == BCNT_LAST)
                        w_adv = 1'b1;
                    else
                        w_bcnt_nxt = r_bcnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_adv) begin
            w_state_nxt = SCAN;
            w_pwm_nxt   = '0;
            if (r_row == ROW_LAST) begin
                w_row_nxt   = '0;
                w_start_nxt = 1'b1;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end
        // Frame boundary: anywhere in IDLE, or the tick that wraps the last row.
        w_bound = (r_state == IDLE) || (w_adv && (r_row == ROW_LAST));
        // The ack cycle is ignored so a held request is not copied twice.
        w_copy  = FrameLoad && !r_ack && w_bound;
    end

    assign w_red_disp = w_copy ? RedPixels : r_red_buf;
    assign w_grn_disp = w_copy ? GrnPixels : r_grn_buf;

    // Columns are computed from next state so they register alongside it.
    always_comb begin
        w_red_cols = '0;
        w_grn_cols = '0;
        if (w_state_nxt == SCAN) begin
            for (int c = 0; c < COLS; c++) begin
                w_red_cols[COLS-1-c] = (w_pwm_nxt < w_red_disp[w_row_nxt][c]);
                w_grn_cols[COLS-1-c] = (w_pwm_nxt < w_grn_disp[w_row_nxt][c]);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_pwm      <= '0;
            r_bcnt     <= '0;
            r_red_buf  <= '0;
            r_grn_buf  <= '0;
            r_red_cols <= '0;
            r_grn_cols <= '0;
            r_start    <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_pwm      <= w_pwm_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_red_buf  <= w_red_disp;
            r_grn_buf  <= w_grn_disp;
            r_red_cols <= w_red_cols;
            r_grn_cols <= w_grn_cols;
            r_start    <= w_start_nxt;
            r_ack      <= w_copy;
        end
    end

    assign RowSel     = r_row;
    assign RedCols    = r_red_cols;
    assign GrnCols    = r_grn_cols;
    assign FrameStart = r_start;
    assign FrameAck   = r_ack;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner (4x4, BPP=2); honours LED_SCAN_BLANK_EN.
module tb_led_matrix_scanner;

    localparam int ROWS = 4, COLS = 4, BPP = 2, FREQDIV = 0, BLANK_CYCLES = 1;
`ifdef LED_SCAN_BLANK_EN
    localparam int BL     = BLANK_CYCLES;
    localparam int FP_EXP = 16;
`else
    localparam int BL     = 0;
    localparam int FP_EXP = 12;
`endif
    localparam int STEPS = 3;
    localparam int RP    = STEPS + BL;
    localparam int FP    = ROWS * RP;

    logic CLK = 1'b0, Reset = 1'b0, EnableCount = 1'b0, FrameLoad = 1'b0;
    logic [ROWS-1:0][COLS-1:0][BPP-1:0] RedPixels = '0, GrnPixels = '0;
    logic       FrameAck, FrameStart;
    logic [1:0] RowSel;
    logic [3:0] RedCols, GrnCols;
    wire [11:0] w_obs = {RowSel, RedCols, GrnCols, FrameStart, FrameAck};

    led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP), .FREQDIV(FREQDIV),
                         .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .CLK(CLK), .Reset(Reset), .EnableCount(EnableCount),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels), .FrameLoad(FrameLoad),
        .FrameAck(FrameAck), .RowSel(RowSel), .RedCols(RedCols), .GrnCols(GrnCols),
        .FrameStart(FrameStart)
    );

    always #5 CLK = ~CLK;

    // Reference: ticks since leaving IDLE, displayed image, pending ack.
    int   nt = 0;
    logic m_ack = 1'b0;
    logic [ROWS-1:0][COLS-1:0][BPP-1:0] m_red = '0, m_grn = '0;
    logic [11:0] exp_q[$];
    int n_vec = 0, n_err = 0;

    function automatic logic [11:0] model_out();
        logic [1:0] rs;
        logic [3:0] rc, gc;
        logic st;
        int g, row, ph;
        rs = '0; rc = '0; gc = '0; st = 1'b0;
        if (nt > 0) begin
            g   = nt - 1;
            row = (g % FP) / RP;
            ph  = g % RP;
            rs  = 2'(row);
            st  = (row == 0) && (ph == 0);
            if (ph < STEPS)
                for (int c = 0; c < COLS; c++) begin
                    rc[COLS-1-c] = (ph < int'(m_red[row][c]));
                    gc[COLS-1-c] = (ph < int'(m_grn[row][c]));
                end
        end
        return {rs, rc, gc, st, m_ack};
    endfunction

    // Drive one cycle of inputs, push the expected post-edge outputs, wait the edge.
    task automatic cyc(input logic en, input logic ld);
        logic bnd, cp;
        EnableCount = en;
        FrameLoad   = ld;
        bnd = (nt == 0) || (en && (nt % FP == 0));
        cp  = ld && !m_ack && bnd;
        if (cp) begin
            m_red = RedPixels;
            m_grn = GrnPixels;
        end
        m_ack = cp;
        if (en) nt++;
        exp_q.push_back(model_out());
        @(posedge CLK);
    endtask

    task automatic model_reset();
        nt = 0; m_ack = 1'b0; m_red = '0; m_grn = '0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        #1 Reset = 1'b1;
        #1 exp_q.push_back(12'h000);
        e = exp_q.pop_front(); n_vec++;
        if (w_obs !== e) begin n_err++; $display("FAIL reset_state got %h exp %h", w_obs, e); end
        model_reset();
        @(negedge CLK) Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL reset_idle[%0d] got %h exp %h", i, w_obs, e); end
        end
    endtask

    task automatic test_idle_load();
        logic [11:0] e;
        int on3 = 0;
        RedPixels = '0; GrnPixels = '0;
        RedPixels[0][0] = 2'd3;
        for (int i = 0; i < FP + 2; i++) begin
            cyc(i >= 2, i == 0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL idle_load[%0d] got %h exp %h", i, w_obs, e); end
            if (i >= 2 && RowSel == 2'd0 && RedCols[3]) on3++;
        end
        n_vec++;
        if (on3 !== 3) begin n_err++; $display("FAIL idle_load_full_level got %0d ticks exp 3", on3); end
    endtask

    task automatic test_midframe_load();
        logic [11:0] e;
        logic req = 1'b0;
        int ack_at = -1;
        RedPixels = '0; GrnPixels = '0;
        RedPixels[1][2] = 2'd1; RedPixels[1][3] = 2'd2; RedPixels[2][0] = 2'd2;
        GrnPixels[2][1] = 2'd3; GrnPixels[3][0] = 2'd1; GrnPixels[0][3] = 2'd3;
        for (int i = 0; i < 2 * FP; i++) begin
            if (i == RP + 1) req = 1'b1;
            cyc(1'b1, req);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL midframe[%0d] got %h exp %h", i, w_obs, e); end
            if (FrameAck) begin
                req = 1'b0;
                if (ack_at < 0) ack_at = i;
            end
        end
        n_vec++;
        if (ack_at !== FP) begin n_err++; $display("FAIL midframe_ack_cycle got %0d exp %0d", ack_at, FP); end
    endtask

    task automatic test_pwm_levels();
        logic [11:0] e;
        int c1 = 0, c2 = 0, g3 = 0, r2 = 0;
        for (int i = 0; i < FP; i++) begin
            cyc(1'b1, 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL pwm_levels[%0d] got %h exp %h", i, w_obs, e); end
            if (RowSel == 2'd1) begin c1 += int'(RedCols[1]); c2 += int'(RedCols[0]); end
            if (RowSel == 2'd2) begin g3 += int'(GrnCols[2]); r2 += int'(RedCols[3]); end
        end
        n_vec++;
        if ({8'(c1), 8'(c2), 8'(g3), 8'(r2)} !== 32'h01020302) begin
            n_err++; $display("FAIL pwm_level_counts got %0d/%0d/%0d/%0d exp 1/2/3/2", c1, c2, g3, r2);
        end
    endtask

    task automatic test_enable_freeze();
        logic [11:0] e;
        int both = 0;
        for (int i = 0; i < FP + 10; i++) begin
            cyc(!(i >= 2 * RP + 2 && i < 2 * RP + 12), 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL freeze[%0d] got %h exp %h", i, w_obs, e); end
            if (RowSel == 2'd2 && RedCols[3] && GrnCols[2]) both++;
        end
        n_vec++;
        if (both !== 12) begin n_err++; $display("FAIL freeze_hold got %0d cycles exp 12", both); end
    endtask

    task automatic test_frame_period();
        logic [11:0] e;
        int s0 = -1, s1 = -1;
        for (int i = 0; i <= 2 * FP; i++) begin
            cyc(1'b1, 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL period[%0d] got %h exp %h", i, w_obs, e); end
            if (FrameStart) begin
                if (s0 < 0) s0 = i;
                else if (s1 < 0) s1 = i;
            end
        end
        n_vec++;
        if (s1 - s0 !== FP_EXP) begin n_err++; $display("FAIL frame_period got %0d exp %0d", s1 - s0, FP_EXP); end
    endtask

    task automatic test_reset_midscan();
        logic [11:0] e;
        int guard = 0;
        while (!(nt > 0 && ((nt - 1) % FP) / RP == 2 && (nt - 1) % RP == 1) && guard < 2 * FP) begin
            cyc(1'b1, 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL pre_reset[%0d] got %h exp %h", guard, w_obs, e); end
            guard++;
        end
        #2 Reset = 1'b1;
        #1 exp_q.push_back(12'h000);
        e = exp_q.pop_front(); n_vec++;
        if (w_obs !== e) begin n_err++; $display("FAIL async_reset got %h exp %h", w_obs, e); end
        model_reset();
        @(negedge CLK) Reset = 1'b0;
        for (int i = 0; i <= FP; i++) begin
            cyc(1'b1, 1'b0);
            @(negedge CLK); e = exp_q.pop_front(); n_vec++;
            if (w_obs !== e) begin n_err++; $display("FAIL post_reset[%0d] got %h exp %h", i, w_obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_midframe_load();
        test_pwm_levels();
        test_enable_freeze();
        test_frame_period();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
